i2s_dsp_capture: RTL and testbench
==================================

// Module: i2s_dsp_capture
// PURPOSE
// Downstream of the WM8731 codec configuration/clock block. Receives the codec ADC serial stream
// (DSP mode, LRP=1, 16-bit, codec slave) on the system clock by oversampling BCLK/LRCK/data.
// Deframes left/right samples and derives a peak-envelope level plus a rate-limited beat pulse
// that drives the headbang motion logic.
// PARAMETERS
// SYNC_STAGES     2      synchronizer depth, identical for bclk, adc_lrck, adc_data (keeps alignment)
// BEAT_THRESHOLD  8000   abs(mono) >= this may fire beat (unsigned 15-bit compare)
// HOLDOFF_FRAMES  12000  frames after a beat during which no new beat fires (~0.25 s @ 48 kHz)
// DECAY_SHIFT     6      envelope decay per frame: env - (env >> DECAY_SHIFT)
// PORTS
// clk           in   1   system clock (50 MHz); must be >= 4x BCLK
// reset         in   1   synchronous, active-low reset
// enable        in   1   capture enable (codec config done); low forces WAIT
// bclk          in   1   codec bit clock, asynchronous to clk
// adc_lrck      in   1   ADC frame pulse, one BCLK period high per 32-BCLK frame
// adc_data      in   1   ADC serial data, MSB first, valid on BCLK rising edge
// left_sample   out  16  last complete left sample (two's complement)
// right_sample  out  16  last complete right sample
// sample_valid  out  1   one-clk pulse when left/right_sample update
// frame_error   out  1   one-clk pulse when a frame is aborted by an early LRCK
// level         out  16  peak envelope of abs(mono), 0..32767
// beat          out  1   one-clk pulse on detected beat
// BEHAVIOUR
// - Reset (reset==0 at posedge clk): all outputs 0, FSM=WAIT, bit_cnt=0, env=0, holdoff=0, sync chains 0.
// - Edge detect: bclk rise = synced bclk 0 in previous clk, 1 now. All sampling only on rise events.
// - FSM WAIT: on rise with synced lrck==1 -> this rise is bit 0 (left MSB); shift data in,
//   bit_cnt<=1, go SHIFT. Rises with lrck==0 are ignored, no error.
// - FSM SHIFT: each rise shifts one bit into 32-bit shift reg, bit_cnt++. Bits 0..15 = left MSB..LSB,
//   bits 16..31 = right MSB..LSB.
//   - lrck==1 on a rise with bit_cnt 1..31: frame_error pulses next clk, partial frame discarded,
//     that rise is treated as bit 0 of a new frame (stay SHIFT, bit_cnt<=1).
//   - Rise capturing bit 31: next clk left/right_sample latch and sample_valid=1 for one clk; go WAIT.
//     Back-to-back frames: next lrck rise is bit 0 of the next frame with no gap.
// - enable==0: FSM forced to WAIT, partial frame dropped, no sample_valid/frame_error/beat;
//   samples, level, holdoff hold their values.
// - Mono: m = (sext17(L) + sext17(R)) >>> 1 (arithmetic), range -32768..32767.
// - a = |m|, saturating: m==-32768 -> a=32767. a is 15-bit unsigned, zero-extended to 16.
// - On clk where sample_valid==1 (level/beat update one clk later):
//   env <= (a > env) ? a : env - (env >> DECAY_SHIFT); level = env.
//   If a >= BEAT_THRESHOLD and holdoff==0: beat=1 for one clk, holdoff <= HOLDOFF_FRAMES.
//   Else if holdoff != 0: holdoff <= holdoff - 1 (saturates at 0).
// - Latency: bit-31 rise detect -> sample_valid +1 clk -> level/beat +1 clk.
// - Reset mid-frame: partial frame lost; first lrck rise after release starts a fresh frame.
// - frame_error and sample_valid never assert in the same clk.
// TESTING
// 1 BCLK=clk/8, frame L=16'h1234 R=16'hABCD -> one sample_valid, left=1234, right=ABCD,
//   sample_valid exactly 1 clk after bit-31 rise detect.
// 2 lrck re-asserted at bit 10, then full frame L=16'h00FF R=16'h7F00 -> frame_error 1 pulse,
//   then left=00FF, right=7F00, no sample_valid for aborted frame.
// 3 L=R=16'h8000 -> a=32767, level=32767, beat pulses 1 clk after sample_valid.
// 4 HOLDOFF_FRAMES=4, 12 frames L=R=16'd20000 -> beats on frames 1, 6, 11 only.
// 5 DECAY_SHIFT=6, frame L=R=16'd32000 then zeros -> level 32000, 31500, 31008, ...
// 6 reset low at bit 20 for 3 clks -> all outputs 0; next full frame L=16'h0001 R=16'hFFFF
//   -> captured correctly, level=0 (m=0).

Source files
------------

// File: rtl/i2s_dsp_capture.sv
// rtl/i2s_dsp_capture.sv - DSP-mode ADC deframer with peak envelope and beat detect
module i2s_dsp_capture #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned BEAT_THRESHOLD = 8000,
  parameter int unsigned HOLDOFF_FRAMES = 12000,
  parameter int unsigned DECAY_SHIFT    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        bclk,
  input  logic        adc_lrck,
  input  logic        adc_data,
  output logic [15:0] left_sample,
  output logic [15:0] right_sample,
  output logic        sample_valid,
  output logic        frame_error,
  output logic [15:0] level,
  output logic        beat
);

  localparam int unsigned HW = $clog2(HOLDOFF_FRAMES + 1);

  typedef enum logic {S_WAIT, S_SHIFT} state_t;

  // Equal-depth chains keep bclk, lrck and data aligned to each other.
  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, data_sync_q;
  logic                   bclk_prev_q;
  logic                   bclk_s, lrck_s, data_s, rise;

  state_t        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          capture_d, error_d;
  logic [15:0]   left_q, right_q;
  logic          sample_valid_q, frame_error_q;

  logic [16:0]   sum;
  logic [15:0]   mono, mono_neg;
  logic [14:0]   mag;
  logic [15:0]   env_q, env_d, env_decay;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          beat_q, beat_d;

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_prev_q;

  // Synchronize the codec signals into clk and remember last bclk for edge detect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], adc_lrck};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], adc_data};
      bclk_prev_q <= bclk_s;
    end
  end

  // Deframer next state: a rise with lrck high always starts a new frame at bit 0.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    capture_d = 1'b0;
    error_d   = 1'b0;
    if (!enable) begin
      state_d   = S_WAIT;
      bit_cnt_d = 5'd0;
    end else if (rise) begin
      case (state_q)
        S_WAIT: begin
          if (lrck_s) begin
            shift_d   = {shift_q[30:0], data_s};
            bit_cnt_d = 5'd1;
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_d = {shift_q[30:0], data_s};
          if (lrck_s) begin
            error_d   = 1'b1;
            bit_cnt_d = 5'd1;
          end else if (bit_cnt_q == 5'd31) begin
            capture_d = 1'b1;
            bit_cnt_d = 5'd0;
            state_d   = S_WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  // Deframer registers and sample latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_WAIT;
      bit_cnt_q      <= 5'd0;
      shift_q        <= 32'd0;
      left_q         <= 16'd0;
      right_q        <= 16'd0;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      sample_valid_q <= capture_d;
      frame_error_q  <= error_d;
      if (capture_d) begin
        left_q  <= shift_d[31:16];
        right_q <= shift_d[15:0];
      end
    end
  end

  // Mono magnitude; -32768 saturates to 32767 so it fits 15 bits.
  always_comb begin
    sum      = {left_q[15], left_q} + {right_q[15], right_q};
    mono     = sum[16:1];
    mono_neg = ~mono + 16'd1;
    if (mono == 16'h8000)
      mag = 15'h7FFF;
    else if (mono[15])
      mag = mono_neg[14:0];
    else
      mag = mono[14:0];
  end

  // Envelope and beat update once per captured frame.
  always_comb begin
    env_decay = env_q - (env_q >> DECAY_SHIFT);
    env_d     = env_q;
    holdoff_d = holdoff_q;
    beat_d    = 1'b0;
    if (sample_valid_q && enable) begin
      env_d = ({1'b0, mag} > env_q) ? {1'b0, mag} : env_decay;
      if ((32'(mag) >= BEAT_THRESHOLD) && (holdoff_q == '0)) begin
        beat_d    = 1'b1;
        holdoff_d = HW'(HOLDOFF_FRAMES);
      end else if (holdoff_q != '0) begin
        holdoff_d = holdoff_q - HW'(1);
      end
    end
  end

  // Envelope, holdoff and beat registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      env_q     <= 16'd0;
      holdoff_q <= '0;
      beat_q    <= 1'b0;
    end else begin
      env_q     <= env_d;
      holdoff_q <= holdoff_d;
      beat_q    <= beat_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = sample_valid_q;
  assign frame_error  = frame_error_q;
  assign level        = env_q;
  assign beat         = beat_q;

endmodule

// File: tb/tb_i2s_dsp_capture.sv
// tb/tb_i2s_dsp_capture.sv - randomized bench for i2s_dsp_capture with integer reference model
module tb_i2s_dsp_capture;

  localparam int HOLD = 4;
  localparam int THR  = 8000;
  localparam int DSH  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        bclk = 1'b0;
  logic        adc_lrck = 1'b0;
  logic        adc_data = 1'b0;
  logic [15:0] left_sample, right_sample, level;
  logic        sample_valid, frame_error, beat;

  i2s_dsp_capture #(
    .SYNC_STAGES(2), .BEAT_THRESHOLD(THR), .HOLDOFF_FRAMES(HOLD), .DECAY_SHIFT(DSH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .adc_lrck(adc_lrck),
    .adc_data(adc_data), .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .frame_error(frame_error), .level(level), .beat(beat)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observation side: counts pulses and grabs values at the expected cycles.
  int          sv_cnt = 0, fe_cnt = 0, beat_cnt = 0;
  logic [15:0] obs_l = 0, obs_r = 0, obs_level = 0;
  logic        lvl_pending = 0, prev_sv = 0;

  always @(negedge clk) begin
    if (lvl_pending) begin
      obs_level   = level;
      lvl_pending = 0;
    end
    if (sample_valid) begin
      sv_cnt++;
      obs_l = left_sample;
      obs_r = right_sample;
      lvl_pending = 1;
      check_eq("sv_fe_same_clk", {31'd0, frame_error}, 32'd0);
    end
    if (frame_error) fe_cnt++;
    if (beat) begin
      beat_cnt++;
      check_eq("beat_one_after_sv", {31'd0, prev_sv}, 32'd1);
    end
    prev_sv = sample_valid;
  end

  // Reference model state.
  int env_m = 0, hold_m = 0;
  int sv0, fe0, bt0;

  task automatic model_reset();
    env_m  = 0;
    hold_m = 0;
  endtask

  task automatic model_frame(input logic [15:0] l, input logic [15:0] r, output int bt);
    int s, m, a;
    s = int'($signed(l)) + int'($signed(r));
    m = s >>> 1;
    a = (m < 0) ? -m : m;
    if (a > 32767) a = 32767;
    bt = 0;
    if (a >= THR && hold_m == 0) begin
      bt = 1;
      hold_m = HOLD;
    end else if (hold_m > 0) begin
      hold_m--;
    end
    env_m = (a > env_m) ? a : env_m - (env_m >> DSH);
  endtask

  // One BCLK period = 8 clk; called and returns at a clk negedge.
  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0; adc_lrck = lr; adc_data = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] l, input logic [15:0] r, input int first, input int last);
    logic [31:0] w;
    w = {l, r};
    for (int i = first; i <= last; i++) send_bit(i == 0, w[31-i]);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic begin_frame();
    sv0 = sv_cnt; fe0 = fe_cnt; bt0 = beat_cnt;
  endtask

  task automatic end_frame(input string tag, input logic [15:0] l, input logic [15:0] r, input int exp_fe);
    int eb;
    model_frame(l, r, eb);
    check_eq({tag, "_sv"}, sv_cnt - sv0, 1);
    check_eq({tag, "_fe"}, fe_cnt - fe0, exp_fe);
    check_eq({tag, "_left"}, obs_l, l);
    check_eq({tag, "_right"}, obs_r, r);
    check_eq({tag, "_level"}, obs_level, env_m);
    check_eq({tag, "_beat"}, beat_cnt - bt0, eb);
  endtask

  task automatic send_frame(input string tag, input logic [15:0] l, input logic [15:0] r, input int idle);
    begin_frame();
    send_bits(l, r, 0, 31);
    idle_bits(idle);
    end_frame(tag, l, r, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_left"}, left_sample, 0);
    check_eq({tag, "_right"}, right_sample, 0);
    check_eq({tag, "_level"}, level, 0);
    check_eq({tag, "_pulses"}, {29'd0, sample_valid, frame_error, beat}, 0);
  endtask

  initial begin
    logic [15:0] rl, rr;
    int b_start;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    idle_bits(2);

    // Frame with explicit bit-31 latency check.
    begin_frame();
    send_bits(16'h1234, 16'hABCD, 0, 30);
    bclk = 1'b0; adc_lrck = 1'b0; adc_data = 1'b1;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("lat_sv_early", {31'd0, sample_valid}, 0);
    @(negedge clk);
    check_eq("lat_sv_on_time", {31'd0, sample_valid}, 1);
    @(negedge clk);
    check_eq("lat_sv_one_clk", {31'd0, sample_valid}, 0);
    repeat (3) @(negedge clk);
    idle_bits(2);
    end_frame("t1", 16'h1234, 16'hABCD, 0);

    // Early lrck at bit 10 aborts the partial frame.
    begin_frame();
    send_bits(16'h5555, 16'h3333, 0, 9);
    send_bits(16'h00FF, 16'h7F00, 0, 31);
    idle_bits(2);
    end_frame("t2", 16'h00FF, 16'h7F00, 1);

    // Full-scale negative saturates the magnitude.
    send_frame("t3", 16'h8000, 16'h8000, 2);
    check_eq("t3_level_max", level, 32767);

    // Holdoff: beats on frames 1, 6, 11 of 12.
    reset = 1'b0; repeat (3) @(negedge clk); reset = 1'b1;
    model_reset();
    b_start = beat_cnt;
    for (int i = 0; i < 12; i++) send_frame("t4", 16'd20000, 16'd20000, 1);
    check_eq("t4_total_beats", beat_cnt - b_start, 3);

    // Decay after a loud frame.
    send_frame("t5a", 16'd32000, 16'd32000, 1);
    check_eq("t5_level0", level, 32000);
    send_frame("t5b", 16'd0, 16'd0, 1);
    check_eq("t5_level1", level, 31500);
    send_frame("t5c", 16'd0, 16'd0, 1);
    check_eq("t5_level2", level, 31008);

    // Enable drop mid-frame discards it and leaves level alone.
    begin_frame();
    send_bits(16'h7000, 16'h7000, 0, 15);
    enable = 1'b0;
    send_bits(16'h7000, 16'h7000, 16, 31);
    enable = 1'b1;
    idle_bits(2);
    check_eq("en_sv", sv_cnt - sv0, 0);
    check_eq("en_fe", fe_cnt - fe0, 0);
    check_eq("en_beat", beat_cnt - bt0, 0);
    check_eq("en_level", level, env_m);
    send_frame("en_after", 16'h0100, 16'hFF00, 1);

    // Reset in the middle of a frame.
    send_bits(16'h4444, 16'h2222, 0, 19);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle_bits(1);
    send_frame("t6", 16'h0001, 16'hFFFF, 2);
    check_eq("t6_level_zero", level, 0);

    // Randomized frames, occasionally aborted.
    for (int n = 0; n < 20; n++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        begin_frame();
        send_bits(16'($urandom), 16'($urandom), 0, $urandom_range(1, 30));
        send_bits(rl, rr, 0, 31);
        idle_bits($urandom_range(1, 3));
        end_frame("rnd_abort", rl, rr, 1);
      end else begin
        send_frame("rnd", rl, rr, $urandom_range(1, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
